// File: rtl/systolic_compute_sequencer.sv
// Sequences one NxN output-stationary systolic multiply per start: snapshot A/B, clear PEs, skewed feed, drain, capture.
// Latency: done pulses 3N+PIPE_LAT cycles after the edge that samples start (13 for N=4, PIPE_LAT=1).
// Backpressure: none; start is sampled only in IDLE, and a start while busy is dropped, not queued.
// Ports: clk/rst (async active-high); start, a_flat, b_flat from the command side; pe_acc from the array;
//        a_in/b_in/pe_en/pe_clear to the array edges; results/busy/done back to the command side.
module systolic_compute_sequencer #(
    parameter int N        = 4,
    parameter int AW       = 16,
    parameter int BW       = 8,
    parameter int RW       = 32,
    parameter int PIPE_LAT = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [N*N*AW-1:0]   a_flat,
    input  logic [N*N*BW-1:0]   b_flat,
    input  logic [N*N*RW-1:0]   pe_acc,
    output logic [N*AW-1:0]     a_in,
    output logic [N*BW-1:0]     b_in,
    output logic                pe_en,
    output logic                pe_clear,
    output logic [N*N*RW-1:0]   results,
    output logic                busy,
    output logic                done
);

    localparam int             TW     = $clog2(3*N-1);
    localparam logic [TW-1:0]  T_LAST = TW'(3*N-3);
    // The drain counter runs PIPE_LAT-1 down to 0; keep at least one bit so PIPE_LAT=0 still elaborates.
    localparam int             DW         = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [DW-1:0]  DRAIN_LOAD = (PIPE_LAT > 0) ? DW'(PIPE_LAT-1) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_CAPTURE
    } state_t;

    state_t              state;
    logic [TW-1:0]       t;
    logic [DW-1:0]       drain_cnt;
    logic [N*N*AW-1:0]   a_snap;
    logic [N*N*BW-1:0]   b_snap;

    // pe_en/pe_clear/busy are registered, so each is loaded on the edge entering the state that owns it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            t         <= '0;
            drain_cnt <= '0;
            a_snap    <= '0;
            b_snap    <= '0;
            results   <= '0;
            pe_en     <= 1'b0;
            pe_clear  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_snap   <= a_flat;
                        b_snap   <= b_flat;
                        pe_clear <= 1'b1;
                        busy     <= 1'b1;
                        state    <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    pe_clear <= 1'b0;
                    pe_en    <= 1'b1;
                    t        <= '0;
                    state    <= S_FEED;
                end
                S_FEED: begin
                    if (t == T_LAST) begin
                        if (PIPE_LAT == 0) begin
                            pe_en <= 1'b0;
                            state <= S_CAPTURE;
                        end else begin
                            drain_cnt <= DRAIN_LOAD;
                            state     <= S_DRAIN;
                        end
                    end else begin
                        t <= t + TW'(1);
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == '0) begin
                        pe_en <= 1'b0;
                        state <= S_CAPTURE;
                    end else begin
                        drain_cnt <= drain_cnt - DW'(1);
                    end
                end
                S_CAPTURE: begin
                    results <= pe_acc;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= S_IDLE;
                end
                default: begin
                    pe_en    <= 1'b0;
                    pe_clear <= 1'b0;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

    // Skewed edge feed: row i carries A[i][k] and column j carries B[k][j] when t == index + k.
    // Looping over k with constant indices keeps every select static; at most one k matches per lane.
    always_comb begin
        a_in = '0;
        b_in = '0;
        if (state == S_FEED) begin
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < N; k++) begin
                    if (int'(t) == i + k) begin
                        a_in[i*AW +: AW] = a_snap[(i*N+k)*AW +: AW];
                    end
                    if (int'(t) == i + k) begin
                        b_in[i*BW +: BW] = b_snap[(k*N+i)*BW +: BW];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_systolic_compute_sequencer.sv
// Bench for systolic_compute_sequencer: drives a behavioural PE array from a_in/b_in/pe_en/pe_clear,
// keeps a queue of expected result matrices with the cycle each done is due, and checks edge skew every cycle.
module tb_systolic_compute_sequencer;

    localparam int N        = 4;
    localparam int AW       = 16;
    localparam int BW       = 8;
    localparam int RW       = 32;
    localparam int PIPE_LAT = 1;
    localparam int AF       = N*N*AW;
    localparam int BF       = N*N*BW;
    localparam int RF       = N*N*RW;
    localparam int OP_LAT   = 3*N + PIPE_LAT;

    typedef logic [511:0] cv_t;
    typedef struct {
        logic [RF-1:0] exp;
        int            due;
    } sb_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [AF-1:0]     a_flat = '0;
    logic [BF-1:0]     b_flat = '0;
    logic [RF-1:0]     pe_acc;
    logic [N*AW-1:0]   a_in;
    logic [N*BW-1:0]   b_in;
    logic              pe_en;
    logic              pe_clear;
    logic [RF-1:0]     results;
    logic              busy;
    logic              done;

    int  cyc = 0;
    int  n_tests = 0;
    int  n_fail = 0;
    int  feed_t = 0;
    sb_t sb[$];
    logic [AF-1:0] cur_a = '0;
    logic [BF-1:0] cur_b = '0;

    systolic_compute_sequencer #(
        .N(N), .AW(AW), .BW(BW), .RW(RW), .PIPE_LAT(PIPE_LAT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .a_flat(a_flat), .b_flat(b_flat), .pe_acc(pe_acc),
        .a_in(a_in), .b_in(b_in), .pe_en(pe_en), .pe_clear(pe_clear),
        .results(results), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural output-stationary array with one product register stage ahead of the accumulator.
    logic [AW-1:0] pa[N][N];
    logic [BW-1:0] pb[N][N];
    logic [RW-1:0] pprod[N][N];
    logic [RW-1:0] pacc[N][N];
    logic [AW-1:0] west[N][N];
    logic [BW-1:0] north[N][N];

    always_comb begin
        west   = '{default: '0};
        north  = '{default: '0};
        pe_acc = '0;
        for (int i = 0; i < N; i++) begin
            west[i][0]  = a_in[i*AW +: AW];
            north[0][i] = b_in[i*BW +: BW];
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 1; j < N; j++) begin
                west[i][j]  = pa[i][j-1];
                north[j][i] = pb[j-1][i];
            end
        end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                pe_acc[(i*N+j)*RW +: RW] = pacc[i][j];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst || pe_clear) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    pa[i][j]    <= '0;
                    pb[i][j]    <= '0;
                    pprod[i][j] <= '0;
                    pacc[i][j]  <= '0;
                end
        end else if (pe_en) begin
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    pa[i][j]    <= west[i][j];
                    pb[i][j]    <= north[i][j];
                    pprod[i][j] <= RW'(west[i][j]) * RW'(north[i][j]);
                    pacc[i][j]  <= pacc[i][j] + pprod[i][j];
                end
        end
    end

    task automatic chk(input string tag, input cv_t got, input cv_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [RF-1:0] golden(input logic [AF-1:0] a, input logic [BF-1:0] b);
        logic [RF-1:0] r;
        logic [RW-1:0] s;
        r = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                s = '0;
                for (int k = 0; k < N; k++)
                    s = s + RW'(a[(i*N+k)*AW +: AW]) * RW'(b[(k*N+j)*BW +: BW]);
                r[(i*N+j)*RW +: RW] = s;
            end
        return r;
    endfunction

    function automatic logic [N*AW-1:0] skew_a(input logic [AF-1:0] a, input int t);
        logic [N*AW-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) begin
            int k;
            k = t - i;
            if (k >= 0 && k < N) v[i*AW +: AW] = a[(i*N+k)*AW +: AW];
        end
        return v;
    endfunction

    function automatic logic [N*BW-1:0] skew_b(input logic [BF-1:0] b, input int t);
        logic [N*BW-1:0] v;
        v = '0;
        for (int j = 0; j < N; j++) begin
            int k;
            k = t - j;
            if (k >= 0 && k < N) v[j*BW +: BW] = b[(k*N+j)*BW +: BW];
        end
        return v;
    endfunction

    function automatic logic [AF-1:0] seq_a();
        logic [AF-1:0] a;
        for (int i = 0; i < N; i++)
            for (int k = 0; k < N; k++)
                a[(i*N+k)*AW +: AW] = AW'(4*i + k + 1);
        return a;
    endfunction

    function automatic logic [BF-1:0] seq_b(input bit ident);
        logic [BF-1:0] b;
        for (int k = 0; k < N; k++)
            for (int j = 0; j < N; j++)
                b[(k*N+j)*BW +: BW] = ident ? BW'(k == j) : BW'(4*k + j + 1);
        return b;
    endfunction

    // Per-cycle monitor: edge feed against the skew formula, and done/results against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (pe_en) begin
                chk("skew_a", cv_t'(a_in), cv_t'(skew_a(cur_a, feed_t)));
                chk("skew_b", cv_t'(b_in), cv_t'(skew_b(cur_b, feed_t)));
            end else begin
                chk("a_in_quiet", cv_t'(a_in), '0);
                chk("b_in_quiet", cv_t'(b_in), '0);
            end
            if (sb.size() > 0 && cyc == sb[0].due) begin
                chk("done_at_due", cv_t'(done), cv_t'(1));
                chk("results", cv_t'(results), cv_t'(sb[0].exp));
                void'(sb.pop_front());
            end else begin
                chk("no_stray_done", cv_t'(done), '0);
            end
        end
        if (pe_clear) feed_t <= 0;
        else if (pe_en) feed_t <= feed_t + 1;
    end

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic launch(input logic [AF-1:0] a, input logic [BF-1:0] b, input bit push, output int s);
        sb_t e;
        @(negedge clk);
        a_flat = a;
        b_flat = b;
        cur_a  = a;
        cur_b  = b;
        start  = 1'b1;
        if (push) begin
            e.exp = golden(a, b);
            e.due = cyc + 1 + OP_LAT;
            sb.push_back(e);
        end
        s = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int  s;
        sb_t e;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", cv_t'(busy), '0);
        chk("rst_done", cv_t'(done), '0);
        chk("rst_pe_en", cv_t'(pe_en), '0);
        chk("rst_pe_clear", cv_t'(pe_clear), '0);
        chk("rst_results", cv_t'(results), '0);
        chk("rst_a_in", cv_t'(a_in), '0);
        chk("rst_b_in", cv_t'(b_in), '0);
        rst = 1'b0;

        // 1: identity B, done latency checked by scoreboard due cycle
        launch(seq_a(), seq_b(1'b1), 1'b1, s);
        chk("t1_clear", cv_t'(pe_clear), cv_t'(1));
        wait_until(s + OP_LAT);
        chk("t1_r00", cv_t'(results[0 +: RW]), cv_t'(1));
        chk("t1_r33", cv_t'(results[15*RW +: RW]), cv_t'(16));
        chk("t1_r12", cv_t'(results[6*RW +: RW]), cv_t'(7));
        wait_until(s + OP_LAT + 2);

        // 2: explicit skew probes at t=0, 3, 9
        launch(seq_a(), seq_b(1'b0), 1'b1, s);
        wait_until(s + 1);
        chk("t2_a_t0", cv_t'(a_in), cv_t'({16'd0, 16'd0, 16'd0, 16'd1}));
        chk("t2_b_t0", cv_t'(b_in), cv_t'({8'd0, 8'd0, 8'd0, 8'd1}));
        wait_until(s + 4);
        chk("t2_a_t3", cv_t'(a_in), cv_t'({16'd13, 16'd10, 16'd7, 16'd4}));
        chk("t2_b_t3", cv_t'(b_in), cv_t'({8'd4, 8'd7, 8'd10, 8'd13}));
        wait_until(s + 10);
        chk("t2_a_t9", cv_t'(a_in), '0);
        chk("t2_b_t9", cv_t'(b_in), '0);
        wait_until(s + OP_LAT + 2);

        // 3: start during FEED t=2 and during CAPTURE is ignored
        launch(seq_a(), seq_b(1'b1), 1'b1, s);
        for (int c = s; c <= s + OP_LAT - 1; c++) begin
            wait_until(c);
            chk("t3_busy", cv_t'(busy), cv_t'(1));
            start = (c == s + 3 || c == s + OP_LAT - 1);
        end
        wait_until(s + OP_LAT);
        start = 1'b0;
        chk("t3_idle_at_done", cv_t'(busy), '0);
        wait_until(s + OP_LAT + 1);
        chk("t3_no_restart_busy", cv_t'(busy), '0);
        chk("t3_no_restart_clr", cv_t'(pe_clear), '0);

        // 4: all-ones operands; a_flat overwritten mid-FEED must not matter
        launch({AF{1'b1}}, {BF{1'b1}}, 1'b1, s);
        wait_until(s + 3);
        a_flat = '0;
        wait_until(s + OP_LAT + 1);
        chk("t4_r00", cv_t'(results[0 +: RW]), cv_t'(4 * 32'h0000_FFFF * 32'h0000_00FF));

        // 5: reset at FEED t=4 aborts with no capture, then a fresh op completes
        launch(seq_a(), seq_b(1'b0), 1'b0, s);
        wait_until(s + 5);
        #2 rst = 1'b1;
        @(negedge clk);
        chk("t5_busy", cv_t'(busy), '0);
        chk("t5_pe_en", cv_t'(pe_en), '0);
        chk("t5_results", cv_t'(results), '0);
        chk("t5_done", cv_t'(done), '0);
        rst = 1'b0;
        launch(seq_a(), seq_b(1'b0), 1'b1, s);
        wait_until(s + OP_LAT + 2);

        // 6: start held high -> back-to-back ops, done pulses OP_LAT+1 apart
        @(negedge clk);
        a_flat = seq_a();
        b_flat = seq_b(1'b0);
        cur_a  = a_flat;
        cur_b  = b_flat;
        start  = 1'b1;
        s      = cyc + 1;
        e.exp  = golden(a_flat, b_flat);
        e.due  = s + OP_LAT;
        sb.push_back(e);
        e.due  = s + 2*OP_LAT + 1;
        sb.push_back(e);
        wait_until(s + OP_LAT + 1);
        chk("t6_reclear", cv_t'(pe_clear), cv_t'(1));
        start = 1'b0;
        wait_until(s + 2*OP_LAT + 3);
        chk("t6_idle", cv_t'(busy), '0);

        chk("sb_drained", cv_t'(sb.size()), '0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
